mul_arbiter: RTL and testbench

//  Shares one negacyclic polynomial multiplier (z = p*u mod (x^N+1), mod 2^QW) between NREQ requesters.

---
 rtl/mul_arb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/mul_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mul_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mul_arb_pkg                                                          |
// | Shared types and helpers for the multiplier arbiter.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int idx_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter                                                           |
// | Combinational round-robin pick: first request at or after ptr.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  int cand;

  // Scan from the farthest offset down so the nearest request wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = 0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand = (int'(ptr) + off) % NREQ;
      if (req[IW'(cand)]) begin
        gnt             = '0;
        gnt[IW'(cand)]  = 1'b1;
        gnt_idx         = IW'(cand);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mul_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mul_arbiter                                                          |
// | Round-robin sharing of one negacyclic multiplier between requesters. |
// | Optional macro MUL_ARB_ERR_EN adds a sticky framing-error output.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int N    = 4,
  parameter int QW   = 5,
  parameter int UW   = 1
) (
  input  logic               clk,
  input  logic               a_rst,
  input  logic [NREQ-1:0]    req_p_vld,
  output logic [NREQ-1:0]    req_p_rdy,
  input  logic [NREQ*QW-1:0] req_p,
  input  logic [NREQ-1:0]    req_p_last,
  input  logic [NREQ-1:0]    req_u_vld,
  output logic [NREQ-1:0]    req_u_rdy,
  input  logic [NREQ*UW-1:0] req_u,
  input  logic [NREQ-1:0]    req_u_last,
  output logic               m_p_vld,
  input  logic               m_p_rdy,
  output logic [QW-1:0]      m_p,
  output logic               m_p_last,
  output logic               m_u_vld,
  input  logic               m_u_rdy,
  output logic [UW-1:0]      m_u,
  output logic               m_u_last,
  input  logic               m_z_vld,
  input  logic [QW-1:0]      m_z,
  input  logic               m_z_last,
  output logic [NREQ-1:0]    res_vld,
  output logic [QW-1:0]      res_z,
  output logic               res_last,
  output logic               busy
`ifdef MUL_ARB_ERR_EN
  ,
  output logic               err
`endif
);

  localparam int c_iw = idx_w(NREQ);
  localparam int c_cw = (N > 1) ? $clog2(N) : 1;
  localparam logic [c_cw-1:0] c_last_beat = c_cw'(N - 1);
  localparam logic [c_iw-1:0] c_last_req  = c_iw'(NREQ - 1);

  state_t            state_q, state_d;
  logic [c_iw-1:0]   rr_q, rr_d;
  logic [c_iw-1:0]   owner_q, owner_d;
  logic [c_cw-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0]   res_vld_q, res_vld_d;
  logic [QW-1:0]     res_z_q, res_z_d;
  logic              res_last_q, res_last_d;

  logic [NREQ-1:0]   w_req;
  logic [NREQ-1:0]   w_gnt;
  logic [c_iw-1:0]   w_gnt_idx;
  logic              w_beat;
  logic              w_any_last;

  assign w_req = req_p_vld & req_u_vld;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (c_iw)
  ) u_rr (
    .req     (w_req),
    .ptr     (rr_q),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    res_vld_d  = '0;
    res_z_d    = res_z_q;
    res_last_d = 1'b0;
    req_p_rdy  = '0;
    req_u_rdy  = '0;
    m_p_vld    = 1'b0;
    m_p        = '0;
    m_p_last   = 1'b0;
    m_u_vld    = 1'b0;
    m_u        = '0;
    m_u_last   = 1'b0;
    w_beat     = 1'b0;
    w_any_last = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|w_gnt) begin
          owner_d = w_gnt_idx;
          state_d = LOAD;
        end
      end
      LOAD: begin
        m_p_vld            = req_p_vld[owner_q];
        m_p                = req_p[int'(owner_q)*QW +: QW];
        m_p_last           = req_p_last[owner_q];
        m_u_vld            = req_u_vld[owner_q];
        m_u                = req_u[int'(owner_q)*UW +: UW];
        m_u_last           = req_u_last[owner_q];
        req_p_rdy[owner_q] = m_p_rdy;
        req_u_rdy[owner_q] = m_u_rdy;
        w_beat             = m_p_vld & m_u_vld & m_p_rdy & m_u_rdy;
        w_any_last         = m_p_last | m_u_last;
        if (w_beat) begin
          if (w_any_last) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (m_z_vld) begin
          res_vld_d[owner_q] = 1'b1;
          res_z_d            = m_z;
          res_last_d         = m_z_last;
          if (m_z_last) begin
            state_d = IDLE;
            rr_d    = (owner_q == c_last_req) ? '0 : owner_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      res_vld_q  <= '0;
      res_z_q    <= '0;
      res_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      res_vld_q  <= res_vld_d;
      res_z_q    <= res_z_d;
      res_last_q <= res_last_d;
    end
  end

  assign res_vld  = res_vld_q;
  assign res_z    = res_z_q;
  assign res_last = res_last_q;
  // Stays high through the cycle that presents the final coefficient.
  assign busy     = (state_q != IDLE) | res_last_q;

`ifdef MUL_ARB_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (w_beat) begin
      if (w_any_last && (cnt_q != c_last_beat)) err_d = 1'b1;
      if (m_p_last != m_u_last)                 err_d = 1'b1;
      if (!w_any_last && (cnt_q == c_last_beat)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mul_arbiter                                                       |
// | Directed + randomized bench with a multiplier model and reference.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mul_arbiter;

  localparam int NREQ = 2;
  localparam int N    = 4;
  localparam int QW   = 5;
  localparam int UW   = 1;

  logic clk = 1'b0;
  logic a_rst;
  logic [NREQ-1:0]    req_p_vld, req_p_rdy, req_p_last;
  logic [NREQ-1:0]    req_u_vld, req_u_rdy, req_u_last;
  logic [NREQ*QW-1:0] req_p;
  logic [NREQ*UW-1:0] req_u;
  logic               m_p_vld, m_p_rdy, m_p_last;
  logic               m_u_vld, m_u_rdy, m_u_last;
  logic [QW-1:0]      m_p;
  logic [UW-1:0]      m_u;
  logic               m_z_vld, m_z_last;
  logic [QW-1:0]      m_z;
  logic [NREQ-1:0]    res_vld;
  logic [QW-1:0]      res_z;
  logic               res_last, busy;
`ifdef MUL_ARB_ERR_EN
  logic               err;
`endif

  always #5 clk = ~clk;

  mul_arbiter #(.NREQ(NREQ), .N(N), .QW(QW), .UW(UW)) dut (
    .clk        (clk),
    .a_rst      (a_rst),
    .req_p_vld  (req_p_vld),
    .req_p_rdy  (req_p_rdy),
    .req_p      (req_p),
    .req_p_last (req_p_last),
    .req_u_vld  (req_u_vld),
    .req_u_rdy  (req_u_rdy),
    .req_u      (req_u),
    .req_u_last (req_u_last),
    .m_p_vld    (m_p_vld),
    .m_p_rdy    (m_p_rdy),
    .m_p        (m_p),
    .m_p_last   (m_p_last),
    .m_u_vld    (m_u_vld),
    .m_u_rdy    (m_u_rdy),
    .m_u        (m_u),
    .m_u_last   (m_u_last),
    .m_z_vld    (m_z_vld),
    .m_z        (m_z),
    .m_z_last   (m_z_last),
    .res_vld    (res_vld),
    .res_z      (res_z),
    .res_last   (res_last),
    .busy       (busy)
`ifdef MUL_ARB_ERR_EN
    ,
    .err        (err)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Requester job store
  logic [19:0] jp   [NREQ][8];
  logic [3:0]  ju   [NREQ][8];
  int          jlen [NREQ][8];
  bit          jgap [NREQ][8];
  int npend[NREQ], head[NREQ], idx[NREQ], gapc[NREQ];
  bit gap_now;

  int rr_model;
  bit draining;
  bit drove_real, chk_now;

  // Multiplier model
  logic [19:0] mpk;
  logic [3:0]  muk;
  int          mcnt;
  logic [19:0] zq;
  int          zidx;

  // Expected result stream and observations
  int          eo[$];
  logic [4:0]  ez[$];
  bit          el[$];
  logic [4:0]  obs_z[$];
  int          grants[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // z = p*u mod (x^4+1), coefficients mod 32
  function automatic logic [19:0] negacyc(input logic [19:0] p, input logic [3:0] u);
    int acc[4];
    logic [19:0] z;
    for (int k = 0; k < 4; k++) acc[k] = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        int t;
        t = int'(p[i*5 +: 5]) * int'(u[j]);
        if (i + j < 4) acc[i+j] += t;
        else           acc[i+j-4] -= t;
      end
    z = '0;
    for (int k = 0; k < 4; k++) z[k*5 +: 5] = 5'(acc[k]);
    return z;
  endfunction

  function automatic int exp_owner();
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (rr_model + k) % NREQ;
      if (head[c] < npend[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit all_quiet();
    bit q;
    q = !draining && (zidx == 4) && (eo.size() == 0);
    for (int r = 0; r < NREQ; r++)
      if (head[r] != npend[r] || idx[r] != 0) q = 1'b0;
    return q;
  endfunction

  task automatic add_job(input int r, input logic [19:0] p, input logic [3:0] u,
                         input int len, input bit gap);
    logic [19:0] pm;
    logic [3:0]  um;
    pm = p;
    um = u;
    for (int i = len; i < 4; i++) begin
      pm[i*5 +: 5] = '0;
      um[i]        = 1'b0;
    end
    jp[r][npend[r]]   = pm;
    ju[r][npend[r]]   = um;
    jlen[r][npend[r]] = len;
    jgap[r][npend[r]] = gap;
    npend[r]++;
  endtask

  task automatic clear_model();
    for (int r = 0; r < NREQ; r++) begin
      npend[r] = 0; head[r] = 0; idx[r] = 0; gapc[r] = 0;
    end
    draining = 0; drove_real = 0; chk_now = 0; gap_now = 0;
    mpk = '0; muk = '0; mcnt = 0; zq = '0; zidx = 4;
    eo.delete(); ez.delete(); el.delete();
  endtask

  task automatic cycle();
    logic beat;
    logic [NREQ-1:0] hs;
    bit popped_last;
    @(posedge clk);
    #1;
    chk_now = drove_real;
    gap_now = 1'b0;
    for (int r = 0; r < NREQ; r++) begin
      if (head[r] < npend[r] && gapc[r] == 0) begin
        req_p_vld[r]          = 1'b1;
        req_u_vld[r]          = 1'b1;
        req_p[r*QW +: QW]     = jp[r][head[r]][idx[r]*5 +: 5];
        req_u[r]              = ju[r][head[r]][idx[r]];
        req_p_last[r]         = (idx[r] == jlen[r][head[r]] - 1);
        req_u_last[r]         = (idx[r] == jlen[r][head[r]] - 1);
      end else begin
        req_p_vld[r]      = 1'b0;
        req_u_vld[r]      = 1'b0;
        req_p[r*QW +: QW] = 5'($urandom);
        req_u[r]          = 1'($urandom);
        req_p_last[r]     = 1'b0;
        req_u_last[r]     = 1'b0;
      end
      if (gapc[r] > 0) begin
        gap_now = 1'b1;
        gapc[r]--;
      end
    end
    m_p_rdy    = ($urandom_range(0, 3) != 0);
    m_u_rdy    = m_p_rdy;
    m_z_vld    = 1'b0;
    m_z        = '0;
    m_z_last   = 1'b0;
    drove_real = 1'b0;
    if (zidx < 4) begin
      if ($urandom_range(0, 2) != 0) begin
        m_z_vld    = 1'b1;
        m_z        = zq[zidx*5 +: 5];
        m_z_last   = (zidx == 3);
        zidx++;
        drove_real = 1'b1;
      end
    end else if ($urandom_range(0, 4) == 0) begin
      m_z_vld  = 1'b1;
      m_z      = 5'($urandom);
      m_z_last = 1'($urandom);
    end

    @(negedge clk);
    beat = m_p_vld & m_p_rdy & m_u_vld & m_u_rdy;
    hs   = req_p_vld & req_p_rdy;
    chk("rdy_p_eq_u", req_p_rdy, req_u_rdy);
    chk("rdy_onehot", $onehot0(req_p_rdy), 1);
    if (draining) chk("rdy_in_drain", req_p_rdy, 0);
    if (gap_now)  chk("vld_in_gap", m_p_vld, 0);
    chk("beat_vs_handshake", beat, |hs);
    popped_last = 1'b0;
    if (chk_now) begin
      chk("res_expected", (eo.size() > 0), 1);
      if (eo.size() > 0) begin
        int o;
        logic [4:0] ze;
        bit l;
        o  = eo.pop_front();
        ze = ez.pop_front();
        l  = el.pop_front();
        chk("res_vld", res_vld, 32'(1) << o);
        chk("res_z", res_z, ze);
        chk("res_last", res_last, l);
        obs_z.push_back(res_z);
        popped_last = l;
      end
    end else begin
      chk("res_vld_idle", res_vld, 0);
    end
    if (draining) chk("busy_drain", busy, 1);
    else if (all_quiet()) begin
      chk("busy_idle", busy, 0);
      chk("rdy_idle", req_p_rdy, 0);
    end

    if (beat) begin
      if (mcnt < 4) begin
        mpk[mcnt*5 +: 5] = m_p;
        muk[mcnt]        = m_u;
      end
      mcnt++;
      if (m_p_last) begin
        zq   = negacyc(mpk, muk);
        zidx = 0;
        mcnt = 0;
        mpk  = '0;
        muk  = '0;
      end
    end
    for (int r = 0; r < NREQ; r++) begin
      if (hs[r]) begin
        if (idx[r] == 0) begin
          chk("grant_owner", r, exp_owner());
          grants.push_back(r);
          rr_model = (r + 1) % NREQ;
        end
        idx[r]++;
        if (jgap[r][head[r]] && idx[r] == 2) gapc[r] = 3;
        if (idx[r] == jlen[r][head[r]]) begin
          logic [19:0] z;
          z = negacyc(jp[r][head[r]], ju[r][head[r]]);
          for (int k = 0; k < 4; k++) begin
            eo.push_back(r);
            ez.push_back(z[k*5 +: 5]);
            el.push_back(k == 3);
          end
          head[r]++;
          idx[r]   = 0;
          draining = 1'b1;
        end
      end
    end
    if (popped_last) draining = 1'b0;
  endtask

  task automatic run(input int maxc);
    int n;
    n = 0;
    while (!all_quiet() && n < maxc) begin
      cycle();
      n++;
    end
    chk("job_timeout", all_quiet(), 1);
    cycle();
  endtask

  task automatic check_obs(input string tag, input logic [19:0] exp);
    chk(tag, obs_z.size(), 4);
    if (obs_z.size() == 4)
      for (int i = 0; i < 4; i++) chk(tag, obs_z[i], exp[i*5 +: 5]);
  endtask

  initial begin
    int n;
    logic [19:0] p1;
    a_rst = 1'b1;
    req_p_vld = '0; req_u_vld = '0; req_p_last = '0; req_u_last = '0;
    req_p = '0; req_u = '0;
    m_p_rdy = 1'b0; m_u_rdy = 1'b0; m_z_vld = 1'b0; m_z = '0; m_z_last = 1'b0;
    clear_model();
    rr_model = 0;
    p1 = {5'd4, 5'd3, 5'd2, 5'd1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_res_vld", res_vld, 0);
    chk("rst_res_z", res_z, 0);
    chk("rst_res_last", res_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", {req_p_rdy, req_u_rdy}, 0);
    chk("rst_m_vld", {m_p_vld, m_u_vld}, 0);
`ifdef MUL_ARB_ERR_EN
    chk("rst_err", err, 0);
`endif
    a_rst = 1'b0;

    // Identity u on requester 0
    obs_z.delete();
    add_job(0, p1, 4'b0001, 4, 1'b0);
    run(200);
    check_obs("t1_z", p1);

    // Multiply by x on requester 1: negacyclic wrap
    obs_z.delete();
    add_job(1, p1, 4'b0010, 4, 1'b0);
    run(200);
    check_obs("t2_z", {5'd3, 5'd2, 5'd1, 5'd28});

    // Both requesting continuously
    grants.delete();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < NREQ; r++)
        add_job(r, 20'($urandom), 4'($urandom), 4, 1'b0);
    run(600);
    chk("t3_grant_count", grants.size(), 4);
    if (grants.size() == 4)
      for (int k = 0; k < 4; k++) chk("t3_grant_seq", grants[k], k % 2);

    // Owner stalls mid-load
    obs_z.delete();
    add_job(0, p1, 4'b0001, 4, 1'b1);
    run(200);
    check_obs("t4_z", p1);

    // Asynchronous reset while draining
    add_job(1, 20'($urandom), 4'($urandom), 4, 1'b0);
    n = 0;
    while (!draining && n < 100) begin
      cycle();
      n++;
    end
    chk("t5_reach_drain", draining, 1);
    cycle();
    #1 a_rst = 1'b1;
    #1;
    chk("t5_rst_res_vld", res_vld, 0);
    chk("t5_rst_res_z", res_z, 0);
    chk("t5_rst_res_last", res_last, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_rdy", {req_p_rdy, req_u_rdy}, 0);
    chk("t5_rst_m_vld", {m_p_vld, m_u_vld}, 0);
    req_p_vld = '0; req_u_vld = '0; m_z_vld = 1'b0;
    clear_model();
    rr_model = 0;
    @(posedge clk);
    @(negedge clk);
    a_rst = 1'b0;
    obs_z.delete();
    add_job(1, p1, 4'b0010, 4, 1'b0);
    run(200);
    check_obs("t5_after_rst_z", {5'd3, 5'd2, 5'd1, 5'd28});

    // Early last on beat 3 of 4
`ifdef MUL_ARB_ERR_EN
    chk("t6_err_before", err, 0);
`endif
    add_job(0, 20'($urandom), 4'($urandom), 3, 1'b0);
    run(200);
`ifdef MUL_ARB_ERR_EN
    chk("t6_err_set", err, 1);
`endif
    add_job(1, 20'($urandom), 4'($urandom), 4, 1'b0);
    run(200);
`ifdef MUL_ARB_ERR_EN
    chk("t6_err_sticky", err, 1);
`endif

    // Randomized mix with stalls
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < NREQ; r++)
        add_job(r, 20'($urandom), 4'($urandom), 4, 1'($urandom_range(0, 1)));
    run(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
